mux2_rr_arbiter: RTL and testbench

// Round-robin arbiter that shares one W-bit 2:1 mux datapath between two requesters.

---
 rtl/mux2_rr_arbiter.sv | 66 ++++++
 tb/tb_mux2_rr_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter sharing a W-bit 2:1 mux into a one-entry output register
module mux2_cell (
    input  logic i0,
    input  logic i1,
    input  logic so,
    output logic z
);
    assign z = so ? i1 : i0;
endmodule

module mux2_rr_arbiter #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [W-1:0]     d0,
    output logic             ack0,
    input  logic             req1,
    input  logic [W-1:0]     d1,
    output logic             ack1,
    output logic             s0,
    output logic [W-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_src,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;
    logic last, pick, space, load;
    logic [W-1:0] m;
    assign y_valid = (state == FULL);
    always_comb begin
        pick  = (req0 && req1) ? ~last : req0 ? 1'b0 : req1 ? 1'b1 : last;
        space = !y_valid || y_ready;
        load  = rst_n && space && (req0 || req1);
        ack0  = load && !pick;
        ack1  = load && pick;
        s0    = pick;
    end
    for (genvar k = 0; k < W; k++) begin : g_mux
        mux2_cell u_cell (.i0(d0[k]), .i1(d1[k]), .so(s0), .z(m[k]));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            y     <= '0;
            y_src <= 1'b0;
            last  <= 1'b1;
            cnt0  <= '0;
            cnt1  <= '0;
        end else if (load) begin
            state <= FULL;
            y     <= m;
            y_src <= pick;
            last  <= pick;
            if (pick) cnt1 <= cnt1 + CNT_W'(1);
            else      cnt0 <= cnt0 + CNT_W'(1);
        end else if (y_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed vector table plus hand sequences against hand-computed expectations
module tb_mux2_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n, req0, req1, y_ready;
    logic [7:0] d0, d1;
    logic ack0, ack1, s0, y_valid, y_src;
    logic [7:0] y;
    logic [1:0] cnt0, cnt1;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.W(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .d0(d0), .ack0(ack0),
        .req1(req1), .d1(d1), .ack1(ack1),
        .s0(s0), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .y_src(y_src), .cnt0(cnt0), .cnt1(cnt1)
    );

    typedef struct {
        logic       rn, r0, r1;
        logic [7:0] d0, d1;
        logic       yr;
        logic       a0, a1, s0;
        logic [7:0] y;
        logic       v, src;
        logic [1:0] c0, c1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    // Drive at negedge, check handshake outputs before the edge and registers after it
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst_n = v.rn; req0 = v.r0; req1 = v.r1; d0 = v.d0; d1 = v.d1; y_ready = v.yr;
        #1;
        chk({tag, ".ack0"}, 32'(ack0), 32'(v.a0));
        chk({tag, ".ack1"}, 32'(ack1), 32'(v.a1));
        chk({tag, ".s0"}, 32'(s0), 32'(v.s0));
        @(posedge clk);
        #1;
        chk({tag, ".y"}, 32'(y), 32'(v.y));
        chk({tag, ".y_valid"}, 32'(y_valid), 32'(v.v));
        chk({tag, ".y_src"}, 32'(y_src), 32'(v.src));
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(v.c0));
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(v.c1));
    endtask

    initial begin
        //            rn r0 r1 d0     d1     yr a0 a1 s0 y      v  src c0 c1
        // reset with both requesting
        tbl.push_back('{0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0});
        // single word from requester 0
        tbl.push_back('{1, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 0, 8'hA5, 1, 0, 1, 0});
        // reset again so contention starts with requester 0
        tbl.push_back('{0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 1, 0, 0, 8'h11, 1, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 8'h22, 1, 1, 1, 1});
        tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 1, 0, 0, 8'h11, 1, 0, 2, 1});
        tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 8'h22, 1, 1, 2, 2});
        tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 1, 0, 0, 8'h11, 1, 0, 3, 2});
        tbl.push_back('{1, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 8'h22, 1, 1, 3, 3});
        // backpressure: load 33, hold 4 clks, then take+reload
        tbl.push_back('{1, 1, 0, 8'h33, 8'h00, 1, 1, 0, 0, 8'h33, 1, 0, 0, 3});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{1, 0, 1, 8'h00, 8'h44, 0, 0, 0, 1, 8'h33, 1, 0, 0, 3});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h44, 1, 0, 1, 1, 8'h44, 1, 1, 0, 0});
        // five words from requester 1, counter wraps
        tbl.push_back('{1, 0, 1, 8'h00, 8'h51, 1, 0, 1, 1, 8'h51, 1, 1, 0, 1});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h52, 1, 0, 1, 1, 8'h52, 1, 1, 0, 2});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h53, 1, 0, 1, 1, 8'h53, 1, 1, 0, 3});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h54, 1, 0, 1, 1, 8'h54, 1, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h55, 1, 0, 1, 1, 8'h55, 1, 1, 0, 1});
        // drain: idle keeps s0 at 1
        tbl.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h55, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h55, 0, 1, 0, 1});
        // mid-operation reset while FULL
        tbl.push_back('{1, 1, 0, 8'h66, 8'h00, 0, 1, 0, 0, 8'h66, 1, 0, 1, 1});
        tbl.push_back('{0, 1, 1, 8'h66, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 8'h77, 8'h88, 1, 1, 0, 0, 8'h77, 1, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 8'h77, 8'h88, 1, 0, 1, 1, 8'h88, 1, 1, 1, 1});

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0; y_ready = 1'b0;
        repeat (2) @(posedge clk);
        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // pointer moves only on load: a lone request that is never acked leaves it alone
        step('{1, 1, 0, 8'h99, 8'h00, 1, 1, 0, 0, 8'h99, 1, 0, 2, 1}, "h_grant0");
        step('{1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h99, 1, 0, 2, 1}, "h_idle");
        step('{1, 0, 1, 8'h00, 8'hBB, 0, 0, 0, 1, 8'h99, 1, 0, 2, 1}, "h_blocked1");
        step('{1, 1, 1, 8'hAA, 8'hBB, 1, 0, 1, 1, 8'hBB, 1, 1, 2, 2}, "h_contest");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
